// File: rtl/controle_condicional.sv
// Conditional-execution sequencer: owns NZCV, evaluates ARM condition codes, sequences ALU execute/writeback.
// Optional ALU timeout (sticky Erro) enabled by defining COND_TIMEOUT_EN.
module controle_condicional #(
  parameter int unsigned MAX_CICLOS_ALU = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Inicia,
  input  logic [3:0] Cond,
  input  logic       BitS,
  input  logic       Pronto,
  input  logic [3:0] FlagsALU,
  output logic [3:0] FlagsNZCV,
  output logic       Inibe,
  output logic       HabALU,
  output logic       HabEscritaReg,
  output logic       HabEscritaFlags,
  output logic       Ocupado,
  output logic       Concluido,
  output logic       Erro
);

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned COND_W  = 4;

  typedef enum logic [1:0] {OCIOSO, AVALIA, EXECUTA, ESCRITA} estado_t;

  if (MAX_CICLOS_ALU < 1 || MAX_CICLOS_ALU > 255) begin : g_param_check
    $error("MAX_CICLOS_ALU out of range 1..255");
  end

  estado_t              estado_q, estado_d;
  logic [COND_W-1:0]    cond_q, cond_d;
  logic                 bits_q, bits_d;
  logic [FLAGS_W-1:0]   flags_lat_q, flags_lat_d;
  logic [FLAGS_W-1:0]   nzcv_q, nzcv_d;
  logic                 inibe_q, inibe_d;
  logic                 hab_alu_q, hab_alu_d;
  logic                 hab_esc_reg_q, hab_esc_reg_d;
  logic                 hab_esc_flags_q, hab_esc_flags_d;
  logic                 ocupado_q, ocupado_d;
  logic                 concluido_q, concluido_d;
  logic                 passa_c;

`ifdef COND_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_CICLOS_ALU + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             erro_q, erro_d;
  assign cnt_inc = cnt_q + CNT_W'(1);
`endif

  // Condition-code evaluation against the architectural flags (N=3, Z=2, C=1, V=0)
  always_comb begin
    passa_c = 1'b0;
    case (cond_q)
      4'b0000: passa_c = nzcv_q[2];
      4'b0001: passa_c = !nzcv_q[2];
      4'b0010: passa_c = nzcv_q[1];
      4'b0011: passa_c = !nzcv_q[1];
      4'b0100: passa_c = nzcv_q[3];
      4'b0101: passa_c = !nzcv_q[3];
      4'b0110: passa_c = nzcv_q[0];
      4'b0111: passa_c = !nzcv_q[0];
      4'b1000: passa_c = nzcv_q[1] && !nzcv_q[2];
      4'b1001: passa_c = !nzcv_q[1] || nzcv_q[2];
      4'b1010: passa_c = (nzcv_q[3] == nzcv_q[0]);
      4'b1011: passa_c = (nzcv_q[3] != nzcv_q[0]);
      4'b1100: passa_c = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
      4'b1101: passa_c = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
      default: passa_c = 1'b1;
    endcase
  end

  // Next state; outputs are registered from the next state so they line up with it
  always_comb begin
    estado_d    = estado_q;
    cond_d      = cond_q;
    bits_d      = bits_q;
    flags_lat_d = flags_lat_q;
    nzcv_d      = nzcv_q;
    inibe_d     = inibe_q;
    concluido_d = 1'b0;
`ifdef COND_TIMEOUT_EN
    cnt_d       = cnt_q;
    erro_d      = erro_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (Inicia) begin
          cond_d   = Cond;
          bits_d   = BitS;
          estado_d = AVALIA;
        end
      end
      AVALIA: begin
        inibe_d = !passa_c;
        if (passa_c) begin
          estado_d = EXECUTA;
`ifdef COND_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          estado_d    = OCIOSO;
          concluido_d = 1'b1;
        end
      end
      EXECUTA: begin
        if (Pronto) begin
          flags_lat_d = FlagsALU;
          concluido_d = 1'b1;
          estado_d    = ESCRITA;
        end
`ifdef COND_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(MAX_CICLOS_ALU)) begin
          erro_d      = 1'b1;
          concluido_d = 1'b1;
          estado_d    = OCIOSO;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      ESCRITA: begin
        if (bits_q) nzcv_d = flags_lat_q;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    hab_alu_d       = (estado_d == EXECUTA);
    hab_esc_reg_d   = (estado_d == ESCRITA);
    hab_esc_flags_d = (estado_d == ESCRITA) && bits_d;
    ocupado_d       = (estado_d != OCIOSO);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q        <= OCIOSO;
      cond_q          <= '0;
      bits_q          <= 1'b0;
      flags_lat_q     <= '0;
      nzcv_q          <= '0;
      inibe_q         <= 1'b0;
      hab_alu_q       <= 1'b0;
      hab_esc_reg_q   <= 1'b0;
      hab_esc_flags_q <= 1'b0;
      ocupado_q       <= 1'b0;
      concluido_q     <= 1'b0;
`ifdef COND_TIMEOUT_EN
      cnt_q           <= '0;
      erro_q          <= 1'b0;
`endif
    end else begin
      estado_q        <= estado_d;
      cond_q          <= cond_d;
      bits_q          <= bits_d;
      flags_lat_q     <= flags_lat_d;
      nzcv_q          <= nzcv_d;
      inibe_q         <= inibe_d;
      hab_alu_q       <= hab_alu_d;
      hab_esc_reg_q   <= hab_esc_reg_d;
      hab_esc_flags_q <= hab_esc_flags_d;
      ocupado_q       <= ocupado_d;
      concluido_q     <= concluido_d;
`ifdef COND_TIMEOUT_EN
      cnt_q           <= cnt_d;
      erro_q          <= erro_d;
`endif
    end
  end

  assign FlagsNZCV       = nzcv_q;
  assign Inibe           = inibe_q;
  assign HabALU          = hab_alu_q;
  assign HabEscritaReg   = hab_esc_reg_q;
  assign HabEscritaFlags = hab_esc_flags_q;
  assign Ocupado         = ocupado_q;
  assign Concluido       = concluido_q;
`ifdef COND_TIMEOUT_EN
  assign Erro            = erro_q;
`else
  assign Erro            = 1'b0;
`endif

endmodule

// File: tb/tb_controle_condicional.sv
// Directed, table-driven bench for controle_condicional (timeout checks only when COND_TIMEOUT_EN is defined).
module tb_controle_condicional;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicia;
  logic [3:0] cond;
  logic       bits;
  logic       pronto;
  logic [3:0] flags_alu;
  logic [3:0] flags_nzcv;
  logic       inibe, hab_alu, hab_esc_reg, hab_esc_flags, ocupado, concluido, erro;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  controle_condicional #(.MAX_CICLOS_ALU(4)) dut (
    .Clock(clk), .Reset(rst), .Inicia(inicia), .Cond(cond), .BitS(bits),
    .Pronto(pronto), .FlagsALU(flags_alu), .FlagsNZCV(flags_nzcv), .Inibe(inibe),
    .HabALU(hab_alu), .HabEscritaReg(hab_esc_reg), .HabEscritaFlags(hab_esc_flags),
    .Ocupado(ocupado), .Concluido(concluido), .Erro(erro)
  );

  typedef struct {
    logic [3:0] cond;
    logic       bits;
    logic [3:0] falu;
    logic [3:0] pre;
    int         delay;
    logic       exp_pass;
    logic [3:0] exp_flags;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference condition table: pairs of (condition, complement) keyed by cond[3:1]
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'b1110 || c == 4'b1111) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = ~(n ^ v);
      default: base = ~z & ~(n ^ v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  // One instruction from OCIOSO; Pronto held high during AVALIA to show it is ignored there
  task automatic exec_instr(input string nm, input logic [3:0] c, input logic b,
                            input logic [3:0] fa, input int delay, input logic exp_pass,
                            input logic [3:0] exp_flags, input logic toggle_inicia);
    inicia = 1'b1; cond = c; bits = b; flags_alu = fa; pronto = 1'b0;
    step();
    inicia = 1'b0; pronto = 1'b1;
    chk({nm, " avalia ocupado"}, 4'(ocupado), 4'd1);
    step();
    if (!exp_pass) begin
      chk({nm, " fail inibe/concl/ocup/alu"}, {inibe, concluido, ocupado, hab_alu}, 4'b1100);
      chk({nm, " fail flags"}, flags_nzcv, exp_flags);
      pronto = 1'b0;
      return;
    end
    chk({nm, " exec inibe/alu/wr/concl"}, {inibe, hab_alu, hab_esc_reg, concluido}, 4'b0100);
    pronto = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (toggle_inicia) inicia = ~inicia;
      step();
      chk({nm, " wait alu"}, {ocupado, hab_alu, hab_esc_reg, concluido}, 4'b1100);
    end
    inicia = 1'b0;
    pronto = 1'b1;
    step();
    pronto = 1'b0;
    chk({nm, " escrita alu/wr/wf/concl"}, {hab_alu, hab_esc_reg, hab_esc_flags, concluido},
        {2'b01, b, 1'b1});
    step();
    chk({nm, " after flags"}, flags_nzcv, exp_flags);
    chk({nm, " after ocup/wr/concl"}, {1'b0, ocupado, hab_esc_reg, concluido}, 4'b0000);
  endtask

  task automatic load_flags(input logic [3:0] f);
    exec_instr("load", 4'b1110, 1'b1, f, 0, 1'b1, f, 1'b0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'b1110, 1'b1, 4'b0100, 4'b0000, 0, 1'b1, 4'b0100};
    vecs[1]  = '{4'b0001, 1'b1, 4'b1111, 4'b0100, 0, 1'b0, 4'b0100};
    vecs[2]  = '{4'b1100, 1'b1, 4'b0011, 4'b1001, 0, 1'b1, 4'b0011};
    vecs[3]  = '{4'b1010, 1'b1, 4'b0011, 4'b1000, 0, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1110, 1'b0, 4'b1111, 4'b0010, 0, 1'b1, 4'b0010};
    vecs[5]  = '{4'b1000, 1'b1, 4'b0110, 4'b0010, 2, 1'b1, 4'b0110};
    vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 4'b0110, 0, 1'b1, 4'b0110};
    vecs[7]  = '{4'b0000, 1'b1, 4'b1111, 4'b0000, 0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b1011, 1'b1, 4'b1111, 4'b0001, 1, 1'b1, 4'b1111};
    vecs[9]  = '{4'b1101, 1'b1, 4'b0000, 4'b1111, 0, 1'b1, 4'b0000};
    vecs[10] = '{4'b1111, 1'b1, 4'b1000, 4'b0000, 0, 1'b1, 4'b1000};

    rst = 1'b1; inicia = 1'b0; cond = '0; bits = 1'b0; pronto = 1'b0; flags_alu = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset flags", flags_nzcv, 4'b0000);
    chk("reset inibe/alu/wr/wf", {inibe, hab_alu, hab_esc_reg, hab_esc_flags}, 4'b0000);
    chk("reset ocup/concl/erro", {1'b0, ocupado, concluido, erro}, 4'b0000);

    for (int i = 0; i < 11; i++) begin
      load_flags(vecs[i].pre);
      exec_instr($sformatf("vec%0d", i), vecs[i].cond, vecs[i].bits, vecs[i].falu,
                 vecs[i].delay, vecs[i].exp_pass, vecs[i].exp_flags, 1'b0);
    end

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        load_flags(4'(f));
        exec_instr($sformatf("sweep nzcv=%0d cond=%0d", f, c), 4'(c), 1'b0, ~4'(f), 0,
                   model_pass(4'(c), 4'(f)), 4'(f), 1'b0);
      end
    end

    // Long ALU wait with Inicia toggling, then reset during the third EXECUTA cycle
    load_flags(4'b0101);
    exec_instr("slow", 4'b1110, 1'b1, 4'b1010, 5, 1'b1, 4'b1010, 1'b1);
    step();
    chk("slow idle ocupado", 4'(ocupado), 4'd0);
    inicia = 1'b1; cond = 4'b1110; bits = 1'b1; flags_alu = 4'b0110;
    step();
    inicia = 1'b0;
    step(); step(); step();
    chk("mid exec alu/ocup", {2'b00, hab_alu, ocupado}, 4'b0011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid reset flags", flags_nzcv, 4'b0000);
    chk("mid reset ocup/alu/inibe/concl", {ocupado, hab_alu, inibe, concluido}, 4'b0000);
    pronto = 1'b1;
    step(); step();
    pronto = 1'b0;
    chk("post reset idle ocup/wr/flags", {ocupado, hab_esc_reg, 2'b00}, 4'b0000);
    chk("post reset flags", flags_nzcv, 4'b0000);

`ifdef COND_TIMEOUT_EN
    load_flags(4'b0011);
    inicia = 1'b1; cond = 4'b1110; bits = 1'b1; flags_alu = 4'b1100; pronto = 1'b0;
    step();
    inicia = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to exec alu/erro", {2'b00, hab_alu, erro}, 4'b0010);
    end
    step();
    chk("to erro/concl/ocup/wr", {erro, concluido, ocupado, hab_esc_reg}, 4'b1100);
    chk("to flags", flags_nzcv, 4'b0011);
    exec_instr("after to", 4'b1110, 1'b1, 4'b0001, 0, 1'b1, 4'b0001, 1'b0);
    chk("erro sticky", 4'(erro), 4'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("erro cleared", 4'(erro), 4'd0);
`else
    chk("erro tied", 4'(erro), 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_condicional.md
# controle_condicional

Multi-cycle sequencer for conditional execution in the ARM-32 core. It owns the architectural NZCV flags register and evaluates each instruction's 4-bit condition field against it. Passing instructions are sequenced through ALU execute and writeback; failing ones are retired as no-ops. It sits between decode and the ALU/register-file write enables.

## Interface
- MAX_CICLOS_ALU, 16: maximum EXECUTA cycles waiting for Pronto (timeout build only); range 1..255
- Clock  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- Inicia  input  1  instruction valid from decode; sampled only in OCIOSO
- Cond  input  4  condition field of the instruction, captured with Inicia
- BitS  input  1  S bit (update flags), captured with Inicia
- Pronto  input  1  ALU result valid; sampled only in EXECUTA
- FlagsALU  input  4  NZCV produced by the ALU; bit 3 = N, 2 = Z, 1 = C, 0 = V; valid with Pronto
- FlagsNZCV  output  4  architectural flags register, same bit order
- Inibe  output  1  registered result of the last condition evaluation (1 = instruction suppressed)
- HabALU  output  1  ALU enable; high for every cycle in EXECUTA
- HabEscritaReg  output  1  register-file write enable; 1-cycle pulse in ESCRITA
- HabEscritaFlags  output  1  high in ESCRITA when the captured BitS = 1
- Ocupado  output  1  high in every state except OCIOSO
- Concluido  output  1  1-cycle retire pulse
- Erro  output  1  sticky ALU timeout flag (timeout build only; tied 0 otherwise)

## Operation
- States: OCIOSO, AVALIA, EXECUTA, ESCRITA.
- OCIOSO: Inicia = 1 captures Cond and BitS, then goes to AVALIA. Otherwise stays.
- AVALIA: evaluates the captured Cond against the current FlagsNZCV.
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - 1110 and 1111 always pass.
  - Pass: Inibe <= 0, go to EXECUTA.
  - Fail: Inibe <= 1, Concluido pulses, go to OCIOSO. No enables are asserted.
- EXECUTA: HabALU = 1. When Pronto = 1, FlagsALU is latched into an internal register and the FSM goes to ESCRITA.
- ESCRITA: HabEscritaReg = 1, HabEscritaFlags = captured BitS, Concluido = 1.
  - If BitS = 1, FlagsNZCV <= the latched flags on this cycle's closing edge.
  - Next state is OCIOSO.
- Inicia outside OCIOSO is ignored. There is no queueing.
- FlagsNZCV changes only in ESCRITA with BitS = 1, or on reset.
- Reset, including mid-operation: state OCIOSO; all outputs 0 (FlagsNZCV 0000, Inibe 0, Erro 0); captured Cond/BitS and latched flags cleared.

## Timing
- Edge numbering: Inicia sampled at edge k.
- AVALIA occupies cycle k+1.
- Fail path: Concluido = 1 and Inibe = 1 in cycle k+2, with the FSM already in OCIOSO. A new Inicia is accepted in that same cycle. Total 2 cycles.
- Pass path: EXECUTA begins in cycle k+2.
  - If Pronto is sampled high at edge m, ESCRITA occupies cycle m+1.
  - Updated FlagsNZCV is visible from cycle m+2.
  - Minimum is 4 cycles with Pronto already high in k+2.
- Back-to-back flag dependency is guaranteed: the next instruction's AVALIA is at cycle m+3 or later, so it always sees the updated flags.
- Pronto high in any state other than EXECUTA has no effect.
- Inibe holds its value between evaluations.

## Configuration
- COND_TIMEOUT_EN defined:
  - A counter of width $clog2(MAX_CICLOS_ALU+1) clears on entry to EXECUTA and increments each EXECUTA cycle without Pronto.
  - If the counter reaches MAX_CICLOS_ALU with Pronto still 0: Erro <= 1 (sticky until Reset), FSM goes to OCIOSO, Concluido pulses, no writes occur, FlagsNZCV is unchanged.
  - Pronto in the same cycle as the limit wins: normal ESCRITA.
- COND_TIMEOUT_EN undefined: no counter; EXECUTA waits indefinitely; Erro tied 0.

## Test plan
- Reset, then Inicia with Cond = 1110, BitS = 1, Pronto high from k+2, FlagsALU = 0100 -> HabALU in k+2, HabEscritaReg/HabEscritaFlags/Concluido in k+3, FlagsNZCV = 0100 in k+4.
- FlagsNZCV = 0100, Cond = 0001 (NE) -> Inibe = 1 and Concluido in k+2; HabALU/HabEscritaReg never assert; flags unchanged.
- Sweep all 16 Cond values against all 16 NZCV values, loading flags via BitS = 1 instructions -> pass/fail matches the table. Example: NZCV 1001, GT passes; NZCV 1000, GE fails.
- BitS = 0, FlagsALU = 1111, FlagsNZCV = 0010 -> HabEscritaReg pulses, HabEscritaFlags = 0, flags stay 0010.
- Pronto delayed 5 cycles, Inicia toggled during EXECUTA, Reset asserted in the 3rd EXECUTA cycle of a second run -> extra Inicia ignored; after reset: OCIOSO, Ocupado 0, FlagsNZCV 0000.
- COND_TIMEOUT_EN, MAX_CICLOS_ALU = 4, Pronto held low -> Erro = 1 and Concluido after 4 EXECUTA cycles, no write enables. Erro persists through the next normal instruction and clears only on Reset.
